// File: rtl/imem_load_ctrl.sv
// Instruction-memory refill front end: round-robin arbitration over
// toggle-encoded load requests, AXI read start, and beat-to-word unpacking.
module imem_load_ctrl #(
  parameter int NUM_REQ         = 2,
  parameter int AXI_ADDR_WIDTH  = 42,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int INST_DATA_WIDTH = 32,
  parameter int NUM_INST_IN     = AXI_DATA_WIDTH / INST_DATA_WIDTH,
  parameter int MEM_REQ_W       = 16,
  parameter int INST_ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_toggle,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MEM_REQ_W-1:0]  req_size,
  output logic [NUM_REQ-1:0]            req_done_toggle,
  input  logic                          imem_wr_start,
  output logic                          ap_start_rd,
  output logic [AXI_ADDR_WIDTH-1:0]     ctrl_addr_offset_rd,
  output logic [MEM_REQ_W-1:0]          ctrl_xfer_size_in_bytes_rd,
  input  logic                          ap_done_rd,
  input  logic                          rd_tvalid,
  output logic                          rd_tready,
  input  logic [AXI_DATA_WIDTH-1:0]     rd_tdata,
  output logic                          imem_wr_valid,
  output logic [INST_ADDR_WIDTH-1:0]    imem_wr_addr,
  output logic [INST_DATA_WIDTH-1:0]    imem_wr_data,
  output logic                          imem_wr_done,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(NUM_INST_IN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, FIN} state_t;

  state_t                       state, state_nxt;
  logic [NUM_REQ-1:0]           req_q, pending, clr, done_tgl;
  logic [PW-1:0]                ptr, gnt, gnt_sel;
  logic                         found, take, accept, wr;
  logic                         done_flag;
  logic [AXI_ADDR_WIDTH-1:0]    addr_r;
  logic [MEM_REQ_W-1:0]         size_r;
  logic [AXI_DATA_WIDTH-1:0]    buf_r;
  logic [CW-1:0]                cnt;
  logic [INST_ADDR_WIDTH-1:0]   wr_addr;

  // First pending source at or after the pointer, wrapping around.
  always_comb begin : search
    int j;
    j       = 0;
    found   = 1'b0;
    gnt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && pending[j]) begin
        found   = 1'b1;
        gnt_sel = PW'(j);
      end
    end
  end

  assign take   = (state == IDLE) && found && imem_wr_start;
  assign clr    = take ? (NUM_REQ'(1) << gnt_sel) : '0;
  assign wr     = (cnt != '0);
  assign accept = rd_tready && rd_tvalid;

  assign rd_tready = (state == XFER) &&
                     ((cnt == '0) || (cnt == CW'(1)));

  assign ap_start_rd                = (state == ISSUE) && (size_r != '0);
  assign ctrl_addr_offset_rd        = addr_r;
  assign ctrl_xfer_size_in_bytes_rd = size_r;
  assign imem_wr_valid              = wr;
  assign imem_wr_addr               = wr_addr;
  assign imem_wr_data               = buf_r[INST_DATA_WIDTH-1:0];
  assign imem_wr_done               = (state == FIN);
  assign busy                       = (state != IDLE);
  assign req_done_toggle            = done_tgl;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (take) state_nxt = ISSUE;
      ISSUE: state_nxt = (size_r == '0) ? FIN : XFER;
      XFER:  if ((ap_done_rd || done_flag) && (cnt == '0) && !accept)
               state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      ptr       <= '0;
      gnt       <= '0;
      addr_r    <= '0;
      size_r    <= '0;
      buf_r     <= '0;
      cnt       <= '0;
      wr_addr   <= '0;
      done_flag <= 1'b0;
      done_tgl  <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_toggle;
      pending <= (pending & ~clr) | (req_toggle ^ req_q);
      if (take) begin
        gnt       <= gnt_sel;
        ptr       <= (gnt_sel == PW'(NUM_REQ - 1)) ? '0 : gnt_sel + 1'b1;
        addr_r    <= req_addr[gnt_sel*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        size_r    <= req_size[gnt_sel*MEM_REQ_W +: MEM_REQ_W];
        wr_addr   <= '0;
        done_flag <= 1'b0;
      end
      if ((state == XFER) && ap_done_rd) done_flag <= 1'b1;
      // A beat may land on the same cycle the last buffered word leaves.
      if (accept) begin
        buf_r <= rd_tdata;
        cnt   <= CW'(NUM_INST_IN);
      end else if (wr) begin
        buf_r <= buf_r >> INST_DATA_WIDTH;
        cnt   <= cnt - 1'b1;
      end
      if (wr) wr_addr <= wr_addr + 1'b1;
      if (state == FIN) done_tgl[gnt] <= ~done_tgl[gnt];
    end
  end

endmodule
